// File: rtl/cgra_pkg.sv
// Shared CGRA tile types: FSM state encoding and default datapath word width.
package cgra_pkg;
   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/full_adder.sv
// Tile adder datapath: a + b + (carry_listen & carry_in); forces zero outputs when on_off is low.
// Purely combinational, no backpressure.
module full_adder
   import cgra_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH
) (
   input  logic             on_off,
   input  logic             carry_listen,
   input  logic             carry_in,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] c,
   output logic             carry_out
);
   logic [width:0] total;
   logic           cin_eff;

   always_comb begin
      cin_eff = carry_listen & carry_in;
      total   = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin_eff};
   end

   assign c         = on_off ? total[width-1:0] : '0;
   assign carry_out = on_off & total[width];
endmodule

// File: rtl/multiword_add_ctrl.sv
// Multi-precision add sequencer, LSW first, carry chained through carry_q. Optional macro: MULTIWORD_ADD_SUB_EN (subtract).
// Latency: sum word registered one cycle after operand fire; 1 word/cycle sustained.
// Backpressure: single output register; op_ready drops while a result is stalled by res_ready.
module multiword_add_ctrl
   import cgra_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MAX_WORDS = 4,
   parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_carry_in,
`ifdef MULTIWORD_ADD_SUB_EN
   input  logic             cmd_sub,
`endif
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_last,
   output logic             res_carry,
   output logic             busy
);
   state_t           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d, len_clamped;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic             cmd_fire, op_fire;
   logic             add_en;
   logic [WIDTH-1:0] add_b, add_c;
   logic             add_co;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      cmd_ready   = 1'b0;
      op_ready    = 1'b0;
      cmd_fire    = 1'b0;
      op_fire     = 1'b0;
      add_en      = 1'b0;
      add_b       = sub_q ? ~op_b : op_b;
      len_clamped = (cmd_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : cmd_len;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            cmd_fire  = cmd_valid;
            // A zero-length command is consumed without leaving IDLE.
            if (cmd_fire && (len_clamped != '0)) begin
               state_d = RUN;
               count_d = len_clamped;
`ifdef MULTIWORD_ADD_SUB_EN
               sub_d   = cmd_sub;
               carry_d = cmd_sub ? 1'b1 : cmd_carry_in;
`else
               sub_d   = 1'b0;
               carry_d = cmd_carry_in;
`endif
            end
         end
         RUN: begin
            op_ready = !res_valid || res_ready;
            op_fire  = op_valid && op_ready;
            add_en   = op_fire;
            if (op_fire) begin
               carry_d = add_co;
               count_d = count_q - LEN_W'(1);
               if (count_q == LEN_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   full_adder #(.width(WIDTH)) u_adder (
      .on_off       (add_en),
      .carry_listen (add_en),
      .carry_in     (carry_q),
      .a            (op_a),
      .b            (add_b),
      .c            (add_c),
      .carry_out    (add_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         carry_q   <= 1'b0;
         sub_q     <= 1'b0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_last  <= 1'b0;
         res_carry <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         // A new word overwrites the register even when the old one drains this same edge.
         if (op_fire) begin
            res_valid <= 1'b1;
            res_sum   <= add_c;
            res_last  <= (count_q == LEN_W'(1));
            res_carry <= add_co;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

   assign busy = (state_q != IDLE) || res_valid;
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl: constant vector table, hand-written reset/abort sequence, random ops vs arithmetic model.
module tb_multiword_add_ctrl;
   localparam int WIDTH = 16;
   localparam int MAXW  = 4;
   localparam int LEN_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_ready, cmd_carry_in;
   logic [LEN_W-1:0] cmd_len;
`ifdef MULTIWORD_ADD_SUB_EN
   logic             cmd_sub;
`endif
   logic             op_valid, op_ready;
   logic [WIDTH-1:0] op_a, op_b;
   logic             res_valid, res_ready, res_last, res_carry, busy;
   logic [WIDTH-1:0] res_sum;

   int total = 0;
   int bad   = 0;

   multiword_add_ctrl #(.WIDTH(WIDTH), .MAX_WORDS(MAXW), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_len      (cmd_len),
      .cmd_carry_in (cmd_carry_in),
`ifdef MULTIWORD_ADD_SUB_EN
      .cmd_sub      (cmd_sub),
`endif
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_sum      (res_sum),
      .res_last     (res_last),
      .res_carry    (res_carry),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  len;
      logic        cin;
      logic        sub;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] sum;
      logic        carry;
      logic [1:0]  mode;   // 0: always ready, 1: random, 2: 3-cycle stall on first result
   } vec_t;

   vec_t vecs[8];
   int   n_vec;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Whole operation as one wide integer addition, truncated to the clamped length.
   function automatic void ref_model(input int len, input logic cin, input logic sub,
                                     input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] sum, output logic carry);
      int          eff;
      logic [63:0] m, bb;
      logic [64:0] t;
      logic        ci;
      eff   = (len > MAXW) ? MAXW : len;
      m     = (eff >= 4) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (16 * eff)) - 64'h1);
      bb    = sub ? (~b & m) : (b & m);
      ci    = sub ? 1'b1 : cin;
      t     = {1'b0, a & m} + {1'b0, bb} + {64'h0, ci};
      sum   = t[63:0] & m;
      carry = t[16 * eff];
   endfunction

   task automatic run_op(input int len, input logic cin, input logic sub,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_sum, input logic exp_carry,
                         input int mode, input string name);
      int               eff, op_idx, res_idx, cyc, first, last, stall_left;
      logic             ok, stalled, hold;
      logic [WIDTH-1:0] h_sum;
      logic             h_last, h_carry;
      eff = (len > MAXW) ? MAXW : len;

      cmd_valid    = 1'b1;
      cmd_len      = LEN_W'(len);
      cmd_carry_in = cin;
`ifdef MULTIWORD_ADD_SUB_EN
      cmd_sub      = sub;
`endif
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      chk({name, " cmd_accept"}, {63'h0, ok}, 64'h1);

      if (eff == 0) begin
         for (int i = 0; i < 5; i++) begin
            op_valid  = 1'b1;
            res_ready = 1'b1;
            @(negedge clk);
            chk({name, " noop_state"}, {61'h0, res_valid, cmd_ready, op_ready}, 64'h2);
            @(posedge clk);
            #1;
         end
         op_valid = 1'b0;
         return;
      end

      op_idx = 0; res_idx = 0; cyc = 0; first = -1; last = -1;
      stall_left = 0; stalled = 1'b0; hold = 1'b0;
      h_sum = '0; h_last = 1'b0; h_carry = 1'b0;
      while (res_idx < eff && cyc < 300) begin
         if (mode == 2 && res_valid && !stalled) begin
            stall_left = 3;
            stalled    = 1'b1;
         end
         if (mode == 1) begin
            res_ready = 1'($urandom_range(0, 1));
            op_valid  = (op_idx < eff) && ($urandom_range(0, 3) != 0);
         end else begin
            res_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            op_valid = (op_idx < eff);
         end
         op_a = a[16 * ((op_idx < 4) ? op_idx : 3) +: 16];
         op_b = b[16 * ((op_idx < 4) ? op_idx : 3) +: 16];
         @(negedge clk);
         if (hold)
            chk({name, " hold"}, {46'h0, res_valid, res_sum, res_last},
                {46'h0, 1'b1, h_sum, h_last});
         hold = res_valid && !res_ready;
         h_sum = res_sum; h_last = res_last; h_carry = res_carry;
         if (op_idx < eff)
            chk({name, " run_flags"}, {62'h0, cmd_ready, busy}, 64'h1);
         if (res_valid && !res_ready && op_idx < eff)
            chk({name, " op_ready_stall"}, {63'h0, op_ready}, 64'h0);
         if (op_valid && op_ready) begin
            if (first < 0) first = cyc;
            op_idx++;
         end
         if (res_valid && res_ready) begin
            chk($sformatf("%s sum%0d", name, res_idx), {48'h0, res_sum},
                {48'h0, exp_sum[16 * res_idx +: 16]});
            chk($sformatf("%s last%0d", name, res_idx), {63'h0, res_last},
                {63'h0, (res_idx == eff - 1)});
            if (res_idx == eff - 1) begin
               chk({name, " carry"}, {63'h0, res_carry}, {63'h0, exp_carry});
               last = cyc;
            end
            res_idx++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      op_valid  = 1'b0;
      res_ready = 1'b0;
      chk({name, " result_count"}, 64'(res_idx), 64'(eff));
      if (mode == 0) chk({name, " cycles"}, 64'(last - first), 64'(eff));
      if (mode == 2) chk({name, " cycles"}, 64'(last - first), 64'(eff + 3));
   endtask

   initial begin
      logic [63:0] ms, ra, rb;
      logic        mc, rc, rs;
      int          rl;

      rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_carry_in = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      cmd_sub = 1'b0;
`endif
      op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_flags", {59'h0, cmd_ready, op_ready, res_valid, busy, res_last}, 64'h10);
      chk("reset_sum", {47'h0, res_carry, res_sum}, 64'h0);
      @(posedge clk);
      #1;

      n_vec = 0;
      vecs[n_vec++] = '{len: 4'd1, cin: 1'b0, sub: 1'b0, a: 64'hFFFF, b: 64'h0001,
                        sum: 64'h0000, carry: 1'b1, mode: 2'd0};
      vecs[n_vec++] = '{len: 4'd2, cin: 1'b0, sub: 1'b0, a: 64'h0001_FFFF, b: 64'h0000_0001,
                        sum: 64'h0002_0000, carry: 1'b0, mode: 2'd0};
      vecs[n_vec++] = '{len: 4'd4, cin: 1'b0, sub: 1'b0, a: 64'h1234_5678_9ABC_DEF0,
                        b: 64'h1111_1111_1111_1111, sum: 64'h2345_6789_ABCD_F001,
                        carry: 1'b0, mode: 2'd2};
      vecs[n_vec++] = '{len: 4'd7, cin: 1'b1, sub: 1'b0, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h0,
                        sum: 64'h0, carry: 1'b1, mode: 2'd0};
      vecs[n_vec++] = '{len: 4'd3, cin: 1'b0, sub: 1'b0, a: 64'h0000_8000_8000,
                        b: 64'h0000_8000_8000, sum: 64'h0001_0001_0000, carry: 1'b0, mode: 2'd0};
      vecs[n_vec++] = '{len: 4'd0, cin: 1'b1, sub: 1'b0, a: 64'h1, b: 64'h1,
                        sum: 64'h0, carry: 1'b0, mode: 2'd0};
`ifdef MULTIWORD_ADD_SUB_EN
      vecs[n_vec++] = '{len: 4'd1, cin: 1'b0, sub: 1'b1, a: 64'h0000, b: 64'h0001,
                        sum: 64'hFFFF, carry: 1'b0, mode: 2'd0};
      vecs[n_vec++] = '{len: 4'd1, cin: 1'b0, sub: 1'b1, a: 64'h0005, b: 64'h0003,
                        sum: 64'h0002, carry: 1'b1, mode: 2'd0};
`endif
      for (int i = 0; i < n_vec; i++)
         run_op(int'(vecs[i].len), vecs[i].cin, vecs[i].sub, vecs[i].a, vecs[i].b,
                vecs[i].sum, vecs[i].carry, int'(vecs[i].mode), $sformatf("vec%0d", i));

      // Abort after the first of four words; the pending result must vanish.
      cmd_valid = 1'b1; cmd_len = 3'd4; cmd_carry_in = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      cmd_sub = 1'b0;
`endif
      @(negedge clk);
      chk("abort cmd_ready", {63'h0, cmd_ready}, 64'h1);
      @(posedge clk);
      #1 cmd_valid = 1'b0; op_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0001; res_ready = 1'b0;
      @(negedge clk);
      chk("abort op_ready", {63'h0, op_ready}, 64'h1);
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(negedge clk);
      chk("abort pending", {47'h0, res_valid, res_sum}, {47'h0, 1'b1, 16'h0002});
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort flags", {60'h0, res_valid, cmd_ready, busy, op_ready}, 64'h4);
      @(posedge clk);
      #1;
      run_op(1, 1'b0, 1'b0, 64'h0003, 64'h0004, 64'h0007, 1'b0, 0, "post_abort");

      for (int k = 0; k < 30; k++) begin
         rl = int'($urandom_range(0, 7));
         rc = 1'($urandom_range(0, 1));
`ifdef MULTIWORD_ADD_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         ref_model(rl, rc, rs, ra, rb, ms, mc);
         run_op(rl, rc, rs, ra, rb, ms, mc, 1, $sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
